// File: rtl/servant_gpio_loader.sv
// servant_gpio_loader: buffers a WORDS-long frame, writes it over Wishbone from BASE, then reads back word 0.
module servant_gpio_loader #(
  parameter logic [31:0] BASE    = 32'h4000_0000,
  parameter int          WORDS   = 9,
  parameter int          TIMEOUT = 15
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_ld_valid,
  input  logic [31:0] i_ld_dat,
  output logic        o_ld_ready,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdbk,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_rdt
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  localparam logic [3:0] LAST = 4'(WORDS - 1);
  localparam logic [3:0] FULL = 4'(WORDS);
  localparam logic [7:0] TMO  = 8'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [3:0]  wp_q, wp_d, idx_q, idx_d;
  logic [7:0]  wc_q, wc_d;
  logic        err_d;
  logic [31:0] rdbk_d;
  logic [31:0] buf_q [WORDS];
  logic        ld_fire;
  assign ld_fire = i_ld_valid && o_ld_ready;
  always_comb begin
    state_d = state_q;
    wp_d    = ld_fire ? wp_q + 4'd1 : wp_q;
    idx_d   = idx_q;
    wc_d    = wc_q;
    err_d   = o_err;
    rdbk_d  = o_rdbk;
    case (state_q)
      IDLE: if (i_start && wp_q == FULL) begin
        state_d = WRITE;
        idx_d   = 4'd0;
        wc_d    = 8'd0;
        err_d   = 1'b0;
      end
      WRITE, READ: if (i_wb_ack) begin
        wc_d = 8'd0;
        if (state_q == READ) begin
          rdbk_d  = i_wb_rdt;
          state_d = DONE;
        end else if (idx_q == LAST) state_d = READ;
        else idx_d = idx_q + 4'd1;
      end else if (wc_q == TMO) begin
        // waiting the full budget ends the frame; the read-back is skipped
        err_d   = 1'b1;
        state_d = DONE;
      end else wc_d = wc_q + 8'd1;
      DONE: begin
        wp_d    = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q    <= IDLE;
      wp_q       <= 4'd0;
      idx_q      <= 4'd0;
      wc_q       <= 8'd0;
      o_err      <= 1'b0;
      o_rdbk     <= 32'd0;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_ld_ready <= 1'b1;
      o_wb_cyc   <= 1'b0;
      o_wb_we    <= 1'b0;
      o_wb_adr   <= 32'd0;
      o_wb_dat   <= 32'd0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      idx_q      <= idx_d;
      wc_q       <= wc_d;
      o_err      <= err_d;
      o_rdbk     <= rdbk_d;
      o_done     <= state_d == DONE;
      o_busy     <= state_d == WRITE || state_d == READ;
      o_ld_ready <= state_d == IDLE && wp_d < FULL;
      o_wb_cyc   <= state_d == WRITE || state_d == READ;
      o_wb_we    <= state_d == WRITE;
      o_wb_adr   <= state_d == WRITE ? BASE + {26'd0, idx_d, 2'b00} : state_d == READ ? BASE : 32'd0;
      o_wb_dat   <= state_d == WRITE ? buf_q[idx_d] : 32'd0;
    end
  end
  always_ff @(posedge i_wb_clk) begin
    if (ld_fire) buf_q[wp_q] <= i_ld_dat;
  end
endmodule

// File: tb/tb_servant_gpio_loader.sv
// tb_servant_gpio_loader: randomized frames against a queue-based model with a decoupled bus/done monitor.
module tb_servant_gpio_loader;
  localparam int          WORDS   = 9;
  localparam int          TIMEOUT = 15;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  logic clk = 0, rst_n = 1, ld_valid = 0, start = 0, ack = 0;
  logic [31:0] ld_dat = 0, rdt = 0;
  logic ld_ready, busy, done, err, we, cyc;
  logic [31:0] rdbk, adr, dat;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  servant_gpio_loader dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_ld_valid(ld_valid), .i_ld_dat(ld_dat),
    .o_ld_ready(ld_ready), .i_start(start), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rdbk(rdbk), .o_wb_adr(adr), .o_wb_dat(dat), .o_wb_we(we), .o_wb_cyc(cyc),
    .i_wb_ack(ack), .i_wb_rdt(rdt)
  );
  typedef struct {logic [31:0] adr; logic [31:0] dat; logic we;} txn_t;
  typedef struct {logic err; logic [31:0] rdbk; int left;} res_t;
  txn_t txq[$];
  res_t rq[$];
  txn_t mt;
  res_t mr;
  logic [31:0] m_frame [WORDS];
  int m_wp = 0;
  logic [31:0] m_rdbk = 0;
  logic m_err = 0;
  int dly [WORDS+1];
  logic [31:0] rd_val = 32'h0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // slave: each transaction is acked after dly[n] idle cycles
  int wl = -1, tidx = 0;
  always @(posedge clk) begin
    #1;
    if (!cyc) begin
      ack = 0; wl = -1; tidx = 0;
    end else begin
      if (wl < 0 || ack) begin wl = dly[tidx]; tidx++; end
      else wl--;
      ack = (wl == 0);
    end
    rdt = we ? ~rd_val : rd_val;
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc) begin
        if (txq.size() == 0) begin
          tests++; fails++;
          $display("FAIL bus: unexpected transaction adr %h we %b", adr, we);
        end else if (ack) begin
          mt = txq.pop_front();
          check("wb_adr", adr, mt.adr);
          check("wb_dat", dat, mt.dat);
          check("wb_we", we, mt.we);
        end else check("wb_hold", {adr, dat}, {txq[0].adr, txq[0].dat});
      end
      if (done) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL done: unexpected pulse");
        end else begin
          mr = rq.pop_front();
          check("err", err, mr.err);
          check("rdbk", rdbk, mr.rdbk);
          check("leftover", txq.size(), mr.left);
          txq.delete();
        end
      end
    end
  end
  task automatic set_dly(input int lo, input int hi);
    for (int i = 0; i <= WORDS; i++) dly[i] = $urandom_range(hi, lo);
  endtask
  task automatic load(input logic [31:0] d, input bit with_start = 0);
    bit rdy = m_wp < WORDS;
    ld_valid = 1; ld_dat = d; start = with_start;
    check("ld_ready", ld_ready, rdy);
    if (rdy) begin m_frame[m_wp] = d; m_wp++; end
    @(negedge clk);
    ld_valid = 0; start = 0;
  endtask
  task automatic load_frame(input int n);
    for (int i = 0; i < n; i++) load($urandom);
  endtask
  task automatic do_start(input int hang);
    int exp_lat = 0, k = 0;
    bit acc = (m_wp == WORDS);
    if (hang >= 0) dly[hang] = 1000;
    rd_val = $urandom;
    if (acc) begin
      for (int i = 0; i < WORDS; i++)
        if (hang < 0 || i <= hang) txq.push_back('{BASE + 32'(4 * i), m_frame[i], 1'b1});
      if (hang < 0) begin
        txq.push_back('{BASE, 32'd0, 1'b0});
        m_rdbk = rd_val;
      end
      m_err = hang >= 0;
      rq.push_back('{m_err, m_rdbk, hang >= 0 ? 1 : 0});
      for (int i = 0; i <= WORDS; i++) begin
        if (i == hang) begin exp_lat += TIMEOUT; break; end
        exp_lat += dly[i] + 1;
      end
    end
    start = 1;
    @(negedge clk);
    start = 0;
    if (!acc) begin
      repeat (3) begin
        check("ignored_busy", busy, 0);
        check("ignored_cyc", cyc, 0);
        @(negedge clk);
      end
      return;
    end
    check("busy_at_T", busy, 1);
    check("err_cleared", err, 0);
    while (!done && k < exp_lat + 20) begin @(negedge clk); k++; end
    check("done_latency", k, exp_lat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after", ld_ready, 1);
    m_wp = 0;
  endtask
  initial begin
    int k;
    for (int i = 0; i <= WORDS; i++) dly[i] = 0;
    #2 rst_n = 0;
    @(negedge clk); @(negedge clk);
    check("rst_outs", {cyc, we, busy, done, err, adr, dat}, 0);
    check("rst_rdbk", rdbk, 0);
    check("rst_ready", ld_ready, 1);
    rst_n = 1;
    @(negedge clk);
    // counting pattern, ack every cycle: done ten edges after start
    for (int i = 1; i <= WORDS; i++) load(32'h1111_1111 * i);
    do_start(-1);
    // three wait cycles per transaction
    for (int i = 0; i <= WORDS; i++) dly[i] = 3;
    load_frame(WORDS);
    do_start(-1);
    // ack withheld on write 4
    set_dly(0, 2);
    load_frame(WORDS);
    do_start(4);
    repeat (2) @(negedge clk);
    check("err_sticky", err, 1);
    set_dly(0, 1);
    load_frame(WORDS);
    do_start(-1);
    // start with an incomplete buffer is ignored
    load_frame(WORDS - 1);
    do_start(-1);
    load($urandom);
    do_start(-1);
    // load and start together at wp=8: load taken, start ignored
    set_dly(0, 3);
    load_frame(WORDS - 1);
    load($urandom, 1);
    check("same_cycle_busy", busy, 0);
    check("full_ready", ld_ready, 0);
    load(32'hDEAD_BEEF);
    do_start(-1);
    // reset in the middle of write 6
    set_dly(0, 2);
    dly[6] = 1000;
    load_frame(WORDS);
    for (int i = 0; i <= 6; i++) txq.push_back('{BASE + 32'(4 * i), m_frame[i], 1'b1});
    start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    while (txq.size() > 1 && k < 200) begin @(negedge clk); k++; end
    check("reach_idx6", txq.size(), 1);
    repeat (2) @(negedge clk);
    check("cyc_before_rst", cyc, 1);
    #2 rst_n = 0;
    #1;
    check("midrst_outs", {cyc, we, busy, done, err, adr, dat}, 0);
    check("midrst_rdbk", rdbk, 0);
    check("midrst_ready", ld_ready, 1);
    txq.delete();
    m_wp = 0; m_rdbk = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    set_dly(0, 0);
    load_frame(WORDS);
    do_start(-1);
    // random frames, one with the longest ack delay that still avoids timeout
    for (int f = 0; f < 4; f++) begin
      set_dly(0, 3);
      if (f == 2) dly[$urandom_range(WORDS, 0)] = TIMEOUT - 1;
      load_frame(WORDS);
      do_start(-1);
    end
    check("results_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/servant_gpio_loader.md
# servant_gpio_loader

Wishbone initiator that pushes a nine-word frame into a memory-mapped GPIO register bank. Words are loaded through a ready/valid port into an internal buffer. On a start request the block issues nine single-word writes at consecutive word addresses from `BASE`, then one read-back of word 0, and reports completion. It sits between a host-side sequencer and the GPIO slave's Wishbone port, with a per-transaction ack timeout.

## Interface
Parameters:
- `BASE`, 32'h4000_0000, byte address of register word 0; must be 4-byte aligned.
- `WORDS`, 9, frame length in 32-bit words, range 1..15.
- `TIMEOUT`, 15, maximum cycles a transaction may wait for ack, range 1..255.

Ports:
- `i_wb_clk`  in  1  sole clock, rising edge.
- `i_wb_rst_n`  in  1  reset, asynchronous assert, active low.
- `i_ld_valid`  in  1  load word valid.
- `i_ld_dat`  in  32  load word.
- `o_ld_ready`  out  1  buffer accepts a word.
- `i_start`  in  1  start request, level-sampled.
- `o_busy`  out  1  frame transfer in progress.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  sticky timeout flag.
- `o_rdbk`  out  32  word-0 read-back value.
- `o_wb_adr`  out  32  bus address.
- `o_wb_dat`  out  32  write data.
- `o_wb_we`  out  1  write enable.
- `o_wb_cyc`  out  1  cycle valid.
- `i_wb_ack`  in  1  transaction acknowledge from the slave-side ack generator.
- `i_wb_rdt`  in  32  read data, valid when `i_wb_ack` is high during the read.

## Operation
- Buffer: `WORDS` x 32 storage with write pointer `wp` (0..`WORDS`).
  - `o_ld_ready` = (state==IDLE) && (wp < `WORDS`).
  - On valid&&ready: buf[wp] <= `i_ld_dat`, wp <= wp+1.
  - Words offered while not ready are not consumed.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - `i_start` with wp==`WORDS` (pre-edge value) -> WRITE, idx=0, `o_err` cleared.
  - `i_start` with wp<`WORDS` is ignored, with no error.
  - Load and start in the same cycle: the load is accepted, and the start uses the pre-edge wp.
- WRITE:
  - `o_wb_cyc`=1, `o_wb_we`=1, `o_wb_adr`=`BASE`+4*idx, `o_wb_dat`=buf[idx].
  - On `i_wb_ack`: if idx==`WORDS`-1 -> READ, else idx+1.
  - `o_wb_cyc` stays high across consecutive transactions.
- READ:
  - `o_wb_cyc`=1, `o_wb_we`=0, `o_wb_adr`=`BASE`, `o_wb_dat`=0.
  - On `i_wb_ack`: `o_rdbk` <= `i_wb_rdt`, -> DONE.
- DONE: `o_wb_cyc`=0, `o_done`=1 for exactly one cycle, wp <= 0, -> IDLE.
- Timeout:
  - An 8-bit wait counter clears at the start of each transaction and increments each cycle without ack.
  - When it reaches `TIMEOUT` without ack: `o_err` <= 1, then DONE. The `o_done` pulse is still issued; `o_rdbk` is unchanged.
- `o_busy` = state is WRITE or READ.
- Buffer contents persist after DONE; only wp clears, so every frame must be fully reloaded.
- An ack seen in IDLE or DONE is ignored.

## Timing
- All outputs are registered.
- Reset (`i_wb_rst_n` low, any state) immediately forces:
  - state IDLE, wp 0, idx 0, wait counter 0.
  - `o_wb_cyc` 0, `o_wb_we` 0, `o_wb_adr` 0, `o_wb_dat` 0.
  - `o_busy` 0, `o_done` 0, `o_err` 0, `o_rdbk` 0.
  - `o_ld_ready` is 1 after reset.
  - Buffer contents are undefined.
  - A reset mid-frame drops `o_wb_cyc` asynchronously and abandons the frame.
- Start sampled at edge T: `o_wb_cyc`/`o_busy` are high from T through the final transaction.
- Ack sampled at edge E advances `o_wb_adr`/`o_wb_dat` after E. The next transaction's wait count starts at 0 from E.
- Best case (ack high every cycle): the 9 writes complete on edges T+1..T+9, the read on T+10, and `o_done` is high for cycle T+11.
- Load throughput: one word per cycle.
- Earliest start is the cycle after the `WORDS`-th load edge.
- `o_err` holds until the next accepted start.

## Test plan
- Load 9 words 0x11111111..0x99999999, start, ack every cycle -> writes at 0x40000000..0x40000020 with matching data in order, then read at 0x40000000. With `i_wb_rdt`=0x11111111 at the read ack: `o_rdbk`=0x11111111, `o_done` pulses once at T+11, `o_err`=0.
- Ack delayed 3 cycles per transaction -> each address and data pair holds 4 cycles; `o_done` at T+41.
- Ack withheld on write idx 4 -> `o_err`=1 and `o_done` after 15 idle cycles. No read is issued, `o_rdbk` is unchanged, and the next good frame clears `o_err`.
- Start after only 8 loads -> no bus activity, `o_busy`=0. The 9th load plus start proceeds normally.
- Load beat and start in the same cycle when wp=8 -> start ignored and the word accepted. `o_ld_ready`=0 afterward; a 10th valid is not consumed.
- Reset pulsed during write idx 6 -> `o_wb_cyc` drops immediately and all outputs are zero. `o_ld_ready`=1, and a fresh 9-word frame completes normally.
